// File: rtl/crypto_round_sequencer_if.sv
// Handshake bundle between the crypto-instruction decode (master) and the round sequencer (slave).
interface crypto_round_sequencer_if;
  logic       start;
  logic       mode;
  logic       round_ack;
  logic       abort;
  logic       busy;
  logic       load;
  logic       round_go;
  logic       add;
  logic       show_c;
  logic       show_d;
  logic       done;
  logic       err;
  logic [2:0] round_idx;

  modport master (
    output start, mode, round_ack, abort,
    input  busy, load, round_go, add, show_c, show_d, done, err, round_idx
  );

  modport slave (
    input  start, mode, round_ack, abort,
    output busy, load, round_go, add, show_c, show_d, done, err, round_idx
  );
endinterface

// File: rtl/crypto_round_sequencer.sv
// Sequences one encrypt/decrypt operation: load, NUM_ROUNDS go/ack rounds, show pulse, done pulse.
// Optional WAIT-state watchdog is built only when CRYPTO_SEQ_TIMEOUT_EN is defined.
module crypto_round_sequencer #(
  parameter int NUM_ROUNDS     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  crypto_round_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_ADVANCE,
    S_SHOW,
    S_DONE
  } state_e;

  localparam logic [2:0] LAST_IDX = 3'(NUM_ROUNDS - 1);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 8) begin : g_bad_rounds
    $error("crypto_round_sequencer: NUM_ROUNDS must be 1..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("crypto_round_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

  state_e     state_q, state_d;
  logic [2:0] round_idx_q, round_idx_d;
  logic       mode_q, mode_d;
  logic       err_q, err_d;
  logic       timeout;
  logic       kill;

`ifdef CRYPTO_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog_q, wdog_d;

  // Counter is cleared in ISSUE so it starts at zero on every entry to WAIT.
  always_comb begin
    wdog_d  = wdog_q;
    timeout = 1'b0;
    if (state_q == S_ISSUE) begin
      wdog_d = '0;
    end else if (state_q == S_WAIT && !bus.round_ack) begin
      if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wdog_q <= '0;
    else      wdog_q <= wdog_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      round_idx_q <= 3'd0;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
    end
  end

  // Abort/timeout overrides every transition and leaves round_idx untouched.
  always_comb begin
    state_d     = state_q;
    round_idx_d = round_idx_q;
    mode_d      = mode_q;
    err_d       = err_q;
    kill        = (state_q != S_IDLE) && (bus.abort || timeout);
    if (kill) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_LOAD;
            mode_d  = bus.mode;
            err_d   = 1'b0;
          end
        end
        S_LOAD: begin
          round_idx_d = 3'd0;
          state_d     = S_ISSUE;
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (bus.round_ack) state_d = S_ADVANCE;
        end
        S_ADVANCE: begin
          round_idx_d = round_idx_q + 3'd1;
          state_d     = (round_idx_q == LAST_IDX) ? S_SHOW : S_ISSUE;
        end
        S_SHOW:  state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.load      = (state_q == S_LOAD);
  assign bus.round_go  = (state_q == S_ISSUE);
  assign bus.add       = (state_q == S_ADVANCE);
  assign bus.show_c    = (state_q == S_SHOW) && !mode_q;
  assign bus.show_d    = (state_q == S_SHOW) &&  mode_q;
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;
  assign bus.round_idx = round_idx_q;

endmodule

// File: tb/tb_crypto_round_sequencer.sv
// Bench for crypto_round_sequencer: two instances (8 and 4 rounds) checked every cycle against
// a phase/round-count model, plus directed scenarios with literal expectations.
module tb_crypto_round_sequencer;

  localparam int NR0 = 8;
  localparam int NR1 = 4;
  localparam int TO  = 15;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_GO   = 2;
  localparam int M_WAIT = 3;
  localparam int M_ADD  = 4;
  localparam int M_SHOW = 5;
  localparam int M_DONE = 6;

  typedef struct packed {
    logic       busy;
    logic       load;
    logic       go;
    logic       add;
    logic       sc;
    logic       sd;
    logic       done;
    logic       err;
    logic [2:0] idx;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic st[2]  = '{1'b0, 1'b0};
  logic md[2]  = '{1'b0, 1'b0};
  logic ack[2] = '{1'b0, 1'b0};
  logic ab[2]  = '{1'b0, 1'b0};
  obs_t obs[2];

  crypto_round_sequencer_if bus8 ();
  crypto_round_sequencer_if bus4 ();

  assign bus8.start = st[0];  assign bus8.mode = md[0];
  assign bus8.round_ack = ack[0];  assign bus8.abort = ab[0];
  assign bus4.start = st[1];  assign bus4.mode = md[1];
  assign bus4.round_ack = ack[1];  assign bus4.abort = ab[1];

  assign obs[0] = {bus8.busy, bus8.load, bus8.round_go, bus8.add, bus8.show_c,
                   bus8.show_d, bus8.done, bus8.err, bus8.round_idx};
  assign obs[1] = {bus4.busy, bus4.load, bus4.round_go, bus4.add, bus4.show_c,
                   bus4.show_d, bus4.done, bus4.err, bus4.round_idx};

  crypto_round_sequencer #(.NUM_ROUNDS(NR0), .TIMEOUT_CYCLES(TO)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8));
  crypto_round_sequencer #(.NUM_ROUNDS(NR1), .TIMEOUT_CYCLES(TO)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4));

  int total = 0;
  int bad   = 0;

  // Model: phase of the operation, rounds completed so far, latched mode and sticky error.
  int m_step[2]   = '{0, 0};
  int m_rounds[2] = '{0, 0};
  int m_idx[2]    = '{0, 0};
  int m_wc[2]     = '{0, 0};
  bit m_mode[2]   = '{1'b0, 1'b0};
  bit m_err[2]    = '{1'b0, 1'b0};

  function automatic int nr_of(int d);
    return (d == 0) ? NR0 : NR1;
  endfunction

  function automatic void model_reset(int d);
    m_step[d] = M_IDLE; m_rounds[d] = 0; m_idx[d] = 0; m_wc[d] = 0;
    m_mode[d] = 1'b0;   m_err[d] = 1'b0;
  endfunction

  function automatic void model_step(int d);
    if (m_step[d] != M_IDLE && ab[d]) begin
      m_step[d] = M_IDLE;
      m_err[d]  = 1'b1;
      return;
    end
    case (m_step[d])
      M_IDLE: if (st[d]) begin
        m_step[d] = M_LOAD; m_mode[d] = md[d]; m_err[d] = 1'b0;
      end
      M_LOAD: begin m_rounds[d] = 0; m_idx[d] = 0; m_step[d] = M_GO; end
      M_GO:   begin m_wc[d] = 0; m_step[d] = M_WAIT; end
      M_WAIT: begin
        if (ack[d]) m_step[d] = M_ADD;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
        else begin
          m_wc[d]++;
          if (m_wc[d] == TO) begin m_step[d] = M_IDLE; m_err[d] = 1'b1; end
        end
`endif
      end
      M_ADD: begin
        m_rounds[d]++;
        m_idx[d]  = (m_idx[d] + 1) % 8;
        m_step[d] = (m_rounds[d] == nr_of(d)) ? M_SHOW : M_GO;
      end
      M_SHOW:  m_step[d] = M_DONE;
      default: m_step[d] = M_IDLE;
    endcase
  endfunction

  function automatic obs_t expect_of(int d);
    obs_t e;
    e      = '0;
    e.busy = (m_step[d] != M_IDLE);
    e.load = (m_step[d] == M_LOAD);
    e.go   = (m_step[d] == M_GO);
    e.add  = (m_step[d] == M_ADD);
    e.sc   = (m_step[d] == M_SHOW) && !m_mode[d];
    e.sd   = (m_step[d] == M_SHOW) &&  m_mode[d];
    e.done = (m_step[d] == M_DONE);
    e.err  = m_err[d];
    e.idx  = 3'(m_idx[d]);
    return e;
  endfunction

  // Per-cycle compare on the falling edge, then advance the model with this cycle's inputs.
  always @(negedge clk) begin : cmp
    obs_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst) model_reset(d);
      e = expect_of(d);
      total++;
      if (obs[d] !== e) begin
        bad++;
        $display("FAIL cycle dut%0d t=%0t: got %h want %h", d, $time, obs[d], e);
      end
      if (rst) model_step(d);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Ack driver: ack_dly>0 schedules round_ack that many cycles after each round_go.
  int ack_dly[2] = '{0, 0};
  int ack_cnt[2] = '{0, 0};
  bit rnd[2]     = '{1'b0, 1'b0};

  task automatic cyc();
    logic a;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rnd[d] && m_step[d] == M_GO) ack_dly[d] = $urandom_range(1, 6);
      if (ack_dly[d] != 0) begin
        a = 1'b0;
        if (ack_cnt[d] > 0) begin
          ack_cnt[d]--;
          a = (ack_cnt[d] == 0);
        end
        if (m_step[d] == M_GO) ack_cnt[d] = ack_dly[d];
        if (rnd[d] && (m_step[d] == M_IDLE || m_step[d] == M_GO) && $urandom_range(0, 3) == 0)
          a = 1'b1;
        ack[d] = a;
      end
    end
  endtask

  int r_gos, r_adds, r_idxbad, r_sc, r_scc, r_sd, r_sdc, r_done, r_donec, r_end, r_idx_end, r_err1;

  task automatic run_op(input int d, input bit mo, input int dly, input bit poke);
    int k;
    r_gos = 0; r_adds = 0; r_idxbad = 0; r_sc = 0; r_scc = -1; r_sd = 0; r_sdc = -1;
    r_done = 0; r_donec = -1;
    ack_dly[d] = dly; ack_cnt[d] = 0;
    st[d] = 1'b1; md[d] = mo;
    cyc();
    st[d] = 1'b0;
    k = 1;
    r_err1 = int'(obs[d].err);
    while (k < 300) begin
      if (obs[d].go) r_gos++;
      if (obs[d].add) begin
        if (int'(obs[d].idx) != r_adds % 8) r_idxbad++;
        r_adds++;
      end
      if (obs[d].sc)   begin r_sc++;   r_scc = k;   end
      if (obs[d].sd)   begin r_sd++;   r_sdc = k;   end
      if (obs[d].done) begin r_done++; r_donec = k; end
      if (!obs[d].busy) break;
      if (poke && k == 4) begin st[d] = 1'b1; md[d] = !mo; end
      else st[d] = 1'b0;
      cyc();
      k++;
    end
    st[d] = 1'b0;
    r_end = k;
    r_idx_end = int'(obs[d].idx);
    ack_dly[d] = 0; ack[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    logic [10:0] ov;
    rst = 1'b0;
    repeat (3) cyc();
    ov = obs[0];
    chk("reset_outputs8", int'(ov), 0);
    ov = obs[1];
    chk("reset_outputs4", int'(ov), 0);
    rst = 1'b1;
    cyc();

    // Encrypt, 8 rounds, ack in the first WAIT cycle.
    run_op(0, 1'b0, 1, 1'b0);
    chk("enc_go_count", r_gos, 8);
    chk("enc_add_count", r_adds, 8);
    chk("enc_idx_seq", r_idxbad, 0);
    chk("enc_show_c_count", r_sc, 1);
    chk("enc_show_c_cycle", r_scc, 26);
    chk("enc_show_d_count", r_sd, 0);
    chk("enc_done_cycle", r_donec, 27);
    chk("enc_idle_cycle", r_end, 28);
    chk("enc_idx_wrap", r_idx_end, 0);
    chk("enc_err", r_err1, 0);

    // Decrypt, 4 rounds, ack 5 cycles after each round_go.
    run_op(1, 1'b1, 5, 1'b0);
    chk("dec_add_count", r_adds, 4);
    chk("dec_show_d_count", r_sd, 1);
    chk("dec_show_c_count", r_sc, 0);
    chk("dec_done_cycle", r_donec, 31);
    chk("dec_idx_end", r_idx_end, 4);

    // Abort together with round_ack in the WAIT cycle of round 2.
    ack_dly[0] = 1; ack_cnt[0] = 0;
    st[0] = 1'b1; md[0] = 1'b0;
    cyc();
    st[0] = 1'b0;
    k = 0;
    while (!(obs[0].go && obs[0].idx == 3'd2) && k < 100) begin cyc(); k++; end
    chk("abort_reach_round2", int'(k < 100), 1);
    ack_dly[0] = 0;
    cyc();
    ack[0] = 1'b1; ab[0] = 1'b1;
    cyc();
    ack[0] = 1'b0; ab[0] = 1'b0;
    chk("abort_busy", int'(obs[0].busy), 0);
    chk("abort_err", int'(obs[0].err), 1);
    chk("abort_idx_hold", int'(obs[0].idx), 2);
    chk("abort_no_add", int'(obs[0].add), 0);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      if (obs[0].done || obs[0].add || obs[0].busy) k++;
      cyc();
    end
    chk("abort_quiet", k, 0);

    // Next start clears err and runs a normal decrypt.
    run_op(0, 1'b1, 2, 1'b0);
    chk("after_abort_err", r_err1, 0);
    chk("after_abort_show_d", r_sd, 1);
    chk("after_abort_done", r_done, 1);
    chk("after_abort_done_cycle", r_donec, 35);

    // Start with flipped mode while busy is ignored.
    run_op(1, 1'b0, 3, 1'b1);
    chk("poke_show_c", r_sc, 1);
    chk("poke_show_d", r_sd, 0);
    chk("poke_done_count", r_done, 1);
    chk("poke_done_cycle", r_donec, 23);
    repeat (3) cyc();
    chk("poke_not_queued", int'(obs[1].busy), 0);

    // Withheld round_ack.
    ack_dly[0] = 0; ack[0] = 1'b0;
    st[0] = 1'b1; md[0] = 1'b0;
    cyc();
    st[0] = 1'b0;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
    k = 1;
    while (obs[0].busy && k < 200) begin cyc(); k++; end
    chk("timeout_idle_cycle", k, 18);
    chk("timeout_err", int'(obs[0].err), 1);
`else
    for (int i = 0; i < 100; i++) cyc();
    chk("no_timeout_busy", int'(obs[0].busy), 1);
    chk("no_timeout_idx", int'(obs[0].idx), 0);
    ab[0] = 1'b1;
    cyc();
    ab[0] = 1'b0;
    chk("no_timeout_abort_err", int'(obs[0].err), 1);
`endif
    repeat (2) cyc();

    // Asynchronous reset in the WAIT state of round 3.
    ack_dly[0] = 1; ack_cnt[0] = 0;
    st[0] = 1'b1; md[0] = 1'b1;
    cyc();
    st[0] = 1'b0;
    k = 0;
    while (!(obs[0].go && obs[0].idx == 3'd3) && k < 100) begin cyc(); k++; end
    ack_dly[0] = 0; ack[0] = 1'b0;
    cyc();
    cyc();
    chk("prereset_idx", int'(obs[0].idx), 3);
    chk("prereset_busy", int'(obs[0].busy), 1);
    #2 rst = 1'b0;
    #1;
    ov = obs[0];
    chk("midop_reset_all", int'(ov), 0);
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    chk("post_reset_busy", int'(obs[0].busy), 0);
    chk("post_reset_idx", int'(obs[0].idx), 0);

    // Randomized traffic on both instances.
    rnd[0] = 1'b1; rnd[1] = 1'b1;
    ack_dly[0] = 1; ack_dly[1] = 1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        st[d] = ($urandom_range(0, 4) == 0);
        md[d] = 1'($urandom_range(0, 1));
        ab[d] = (m_step[d] == M_LOAD || m_step[d] == M_GO || m_step[d] == M_WAIT) &&
                ($urandom_range(0, 19) == 0);
      end
    end
    rnd[0] = 1'b0; rnd[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin st[d] = 1'b0; ab[d] = 1'b0; ack_dly[d] = 1; end
    repeat (60) cyc();
    chk("drain_idle8", int'(obs[0].busy), 0);
    chk("drain_idle4", int'(obs[1].busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
